// File: rtl/acct_loader_pkg.sv
// Shared types for the access-control configuration loader: FSM states, error causes, bus constants.
package acct_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DONE,
    FAIL
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_BUS,
    ERR_TIMEOUT,
    ERR_MISMATCH
  } err_e;

  localparam logic [3:0] WSTRB_ALL = 4'hF;

  // Word i lives at base + 4*i.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [7:0] idx);
    return base + {22'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/REG_BUS.sv
// Simple register bus: initiator drives addr/write/wdata/wstrb/valid, target returns rdata/ready/error.
interface REG_BUS;
  logic [31:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        valid;
  logic [31:0] rdata;
  logic        ready;
  logic        error;

  modport out (output addr, write, wdata, wstrb, valid, input rdata, ready, error);
  modport in  (input addr, write, wdata, wstrb, valid, output rdata, ready, error);
endinterface

// File: rtl/acct_loader_timer.sv
// Per-beat wait counter; expired_o fires in the stalled cycle that brings the count to TIMEOUT_CYCLES.
module acct_loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired_o = en_i && !clear_i && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/acct_cfg_loader.sv
// REG_BUS initiator that writes NUM_WORDS config words after boot.
// Define ACCT_LOADER_VERIFY_EN to read back and compare each word after writing it.
module acct_cfg_loader
  import acct_loader_pkg::*;
#(
  parameter int unsigned NUM_WORDS      = 9,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [NUM_WORDS-1:0][31:0]  cfg_words_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output err_e                        err_code_o,
  output logic [7:0]                  err_idx_o,
  output state_e                      dbg_state_o,
  REG_BUS.out                         reg_bus_o
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  // Handshake: a beat holds valid and its payload stable until the cycle with ready=1;
  // rdata and error are only looked at in that completing cycle.
  state_e      state;
  logic [7:0]  idx;
  logic        bus_valid, bus_write;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  logic        beat_done, expired;
  logic        go_fail, go_read, go_next;
  err_e        fail_code;
  logic [31:0] cur_word, next_word;

  assign reg_bus_o.valid = bus_valid;
  assign reg_bus_o.write = bus_write;
  assign reg_bus_o.addr  = bus_addr;
  assign reg_bus_o.wdata = bus_wdata;
  assign reg_bus_o.wstrb = bus_wstrb;
  assign dbg_state_o     = state;

  assign beat_done = bus_valid && reg_bus_o.ready;

  acct_loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (beat_done || (state == IDLE)),
    .en_i      (bus_valid && !reg_bus_o.ready),
    .expired_o (expired)
  );

  always_comb begin
    cur_word  = '0;
    next_word = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      if (idx == 8'(i)) cur_word = cfg_words_i[i];
      if (idx + 8'd1 == 8'(i)) next_word = cfg_words_i[i];
    end
  end

  always_comb begin
    go_fail   = 1'b0;
    go_read   = 1'b0;
    go_next   = 1'b0;
    fail_code = ERR_NONE;
    if (state == WRITE || state == READ) begin
      if (beat_done) begin
        if (reg_bus_o.error) begin
          go_fail   = 1'b1;
          fail_code = ERR_BUS;
        end
`ifdef ACCT_LOADER_VERIFY_EN
        else if (state == WRITE) begin
          go_read = 1'b1;
        end else if (reg_bus_o.rdata != cur_word) begin
          go_fail   = 1'b1;
          fail_code = ERR_MISMATCH;
        end
`endif
        else begin
          go_next = 1'b1;
        end
      end else if (expired) begin
        go_fail   = 1'b1;
        fail_code = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      idx        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
      err_idx_o  <= '0;
      bus_valid  <= 1'b0;
      bus_write  <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            err_idx_o  <= '0;
            idx        <= '0;
            busy_o     <= 1'b1;
            state      <= WRITE;
            bus_valid  <= 1'b1;
            bus_write  <= 1'b1;
            bus_addr   <= BASE_ADDR;
            bus_wdata  <= cfg_words_i[0];
            bus_wstrb  <= WSTRB_ALL;
          end
        end
        WRITE, READ: begin
          if (go_fail) begin
            state      <= FAIL;
            err_o      <= 1'b1;
            err_code_o <= fail_code;
            err_idx_o  <= idx;
            busy_o     <= 1'b0;
            bus_valid  <= 1'b0;
            bus_write  <= 1'b0;
            bus_wstrb  <= '0;
          end else if (go_read) begin
            // Readback reuses the same address; valid stays high for a back-to-back beat.
            state     <= READ;
            bus_write <= 1'b0;
            bus_wstrb <= '0;
          end else if (go_next) begin
            if (idx == LAST_IDX) begin
              state     <= DONE;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              bus_valid <= 1'b0;
              bus_write <= 1'b0;
              bus_wstrb <= '0;
            end else begin
              idx       <= idx + 8'd1;
              state     <= WRITE;
              bus_write <= 1'b1;
              bus_wstrb <= WSTRB_ALL;
              bus_addr  <= word_addr(BASE_ADDR, idx + 8'd1);
              bus_wdata <= next_word;
            end
          end
        end
        DONE:    state <= IDLE;
        FAIL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acct_cfg_loader.sv
// Bench for acct_cfg_loader: table of sequence scenarios against a reactive REG_BUS slave with a beat scoreboard.
module tb_acct_cfg_loader;
  import acct_loader_pkg::*;

  localparam int NW = 9;
  localparam int TO = 16;
`ifdef ACCT_LOADER_VERIFY_EN
  localparam int BPW = 2;
  localparam int NT  = 5;
`else
  localparam int BPW = 1;
  localparam int NT  = 4;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [NW-1:0][31:0]  cfg = '0;
  logic                 busy, done, err;
  err_e                 err_code;
  logic [7:0]           err_idx;
  state_e               st;

  REG_BUS bus();

  acct_cfg_loader #(
    .NUM_WORDS      (NW),
    .BASE_ADDR      (32'h0),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .cfg_words_i (cfg),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_code_o  (err_code),
    .err_idx_o   (err_idx),
    .dbg_state_o (st),
    .reg_bus_o   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  logic [68:0] exp_q[$];

  // Slave behaviour knobs
  int stall_word = -1;
  int stall_left = 0;
  int err_word   = -1;
  bit stuck      = 1'b0;
  int lock_from  = NW;
  logic [31:0] mem [NW];
  bit          pend = 1'b0;
  logic [68:0] pend_item;

  typedef struct {
    int   stall_word;
    int   stall_n;
    int   err_word;
    bit   stuck;
    int   lock_from;
    int   n_beats;
    bit   exp_done;
    bit   exp_err;
    err_e exp_code;
    int   exp_idx;
    int   exp_end;
    int   exp_valid;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: unexpected event", name);
  endtask

  // Reactive slave: decides ready/error/rdata for the current cycle on the falling edge.
  always @(negedge clk) begin
    logic [68:0] item;
    int          w;
    bus.ready = 1'b1;
    bus.error = 1'b0;
    bus.rdata = 32'h0;
    if (bus.valid === 1'b1) begin
      w    = int'(bus.addr >> 2);
      item = {bus.write, bus.wstrb, bus.addr, (bus.write ? bus.wdata : 32'h0)};
      if (pend) check("hold_stable", 72'(item), 72'(pend_item));
      if (stuck) bus.ready = 1'b0;
      else if (bus.write && w == stall_word && stall_left > 0) begin
        bus.ready = 1'b0;
        stall_left--;
      end
      if (bus.ready) begin
        if (bus.write && w == err_word) bus.error = 1'b1;
        else if (bus.write && w < NW) mem[w] = bus.wdata;
        if (!bus.write && w < NW) bus.rdata = (w >= lock_from) ? 32'h0 : mem[w];
        if (exp_q.size() == 0) fail_now("extra_beat");
        else check("beat", 72'(item), 72'(exp_q.pop_front()));
      end
      pend      = !bus.ready;
      pend_item = item;
    end else begin
      pend = 1'b0;
    end
  end

  task automatic push_beats(input int n);
    int          w;
    logic [31:0] a;
    for (int b = 0; b < n; b++) begin
      w = b / BPW;
      a = 32'(w * 4);
      if (b % BPW == 0) exp_q.push_back({1'b1, 4'hF, a, cfg[w]});
      else exp_q.push_back({1'b0, 4'h0, a, 32'h0});
    end
  endtask

  task automatic setup(input vec_t v);
    stall_word = v.stall_word;
    stall_left = v.stall_n;
    err_word   = v.err_word;
    stuck      = v.stuck;
    lock_from  = v.lock_from;
    for (int i = 0; i < NW; i++) cfg[i] = $urandom() | 32'h1;
    push_beats(v.n_beats);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int end_c;
    int vcnt;
    setup(v);
    @(negedge clk);
    start = 1'b1;
    end_c = -1;
    vcnt  = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        check($sformatf("v%0d_busy", id), 72'(busy), 72'(1));
      end
      if (bus.valid === 1'b1) vcnt++;
      if (end_c < 0 && (done === 1'b1 || err === 1'b1)) end_c = c;
    end
    check($sformatf("v%0d_end_cycle", id), 72'(end_c), 72'(v.exp_end));
    check($sformatf("v%0d_valid_cycles", id), 72'(vcnt), 72'(v.exp_valid));
    check($sformatf("v%0d_done", id), 72'(done), 72'(v.exp_done));
    check($sformatf("v%0d_err", id), 72'(err), 72'(v.exp_err));
    check($sformatf("v%0d_code", id), 72'(err_code), 72'(v.exp_code));
    check($sformatf("v%0d_idx", id), 72'(err_idx), 72'(v.exp_idx));
    check($sformatf("v%0d_busy_end", id), 72'(busy), 72'(0));
    check($sformatf("v%0d_beats_left", id), 72'(exp_q.size()), 72'(0));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stop_c;
    vecs[0] = '{-1, 0, -1, 1'b0, NW, NW*BPW,     1'b1, 1'b0, ERR_NONE,     0, NW*BPW+1, NW*BPW};
    vecs[1] = '{ 2, 3, -1, 1'b0, NW, NW*BPW,     1'b1, 1'b0, ERR_NONE,     0, NW*BPW+4, NW*BPW+3};
    vecs[2] = '{-1, 0,  4, 1'b0, NW, 4*BPW+1,    1'b0, 1'b1, ERR_BUS,      4, 4*BPW+2,  4*BPW+1};
    vecs[3] = '{-1, 0, -1, 1'b1, NW, 0,          1'b0, 1'b1, ERR_TIMEOUT,  0, TO+1,     TO};
    vecs[4] = '{-1, 0, -1, 1'b0, 6,  14,         1'b0, 1'b1, ERR_MISMATCH, 6, 15,       14};

    // Reset state
    #1;
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_done", 72'(done), 72'(0));
    check("rst_err", 72'(err), 72'(0));
    check("rst_code", 72'(err_code), 72'(ERR_NONE));
    check("rst_idx", 72'(err_idx), 72'(0));
    check("rst_state", 72'(st), 72'(IDLE));
    check("rst_bus", 72'({bus.valid, bus.write, bus.addr, bus.wdata, bus.wstrb}), 72'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NT; i++) run_vec(vecs[i], i);

    // Reset while word 3 is stalled, then a clean rerun from word 0
    setup('{3, 5, -1, 1'b0, NW, 3*BPW, 1'b0, 1'b0, ERR_NONE, 0, 0, 0});
    @(negedge clk);
    start  = 1'b1;
    stop_c = 3*BPW + 2;
    for (int c = 1; c <= stop_c; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check("mid_addr_w3", 72'(bus.addr), 72'(12));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 72'(bus.valid), 72'(0));
    check("mid_rst_busy", 72'(busy), 72'(0));
    check("mid_rst_state", 72'(st), 72'(IDLE));
    check("mid_rst_beats_left", 72'(exp_q.size()), 72'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_idle_valid", 72'(bus.valid), 72'(0));
    run_vec(vecs[0], 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/acct_cfg_loader.md
Name: acct_cfg_loader

Overview:
REG_BUS initiator that programs the access-control register block after boot. On a start pulse it writes a table of NUM_WORDS 32-bit words to consecutive word addresses and can optionally read each word back to verify it. It reports completion, or the first failing index together with a cause. It sits between the boot/secure-config logic and the REG_BUS demux in front of the access-control slave.

Parameters:
NUM_WORDS, 9, words to program (NB_SLAVE*3 for 3 slaves); must be 1..256
BASE_ADDR, 32'h0, byte address of word 0; word i is at BASE_ADDR + 4*i
TIMEOUT_CYCLES, 64, maximum cycles waiting for ready per beat; must be at least 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
start_i  in  1  single-cycle start request
cfg_words_i  in  NUM_WORDS x 32  words to write; must be stable while busy_o=1
busy_o  out  1  sequence in progress
done_o  out  1  sticky: sequence completed without error
err_o  out  1  sticky: sequence aborted
err_code_o  out  2  acct_loader_pkg::err_e cause
err_idx_o  out  8  index of the failing word
reg_bus_o  REG_BUS.out  -  addr/write/wdata/wstrb/valid driven; rdata/ready/error sampled
Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values: all outputs 0, valid=0, write=0, addr=0, wdata=0, wstrb=0, err_code_o=ERR_NONE, state IDLE.
- Bus handshake:
  - A beat is valid=1 with addr/write/wdata/wstrb held stable until the cycle where ready=1; that cycle completes the beat.
  - error and rdata are sampled only in the completing cycle.
  - wstrb=4'hF on writes and 4'h0 on reads.
  - valid drops in the cycle after completion unless the next beat follows immediately (back-to-back is allowed).
- States: IDLE, WRITE, READ (verify build only), DONE, FAIL.
- IDLE: start_i=1 clears done_o/err_o/err_code_o/err_idx_o, sets idx=0, busy_o=1 and goes to WRITE. valid rises in the next cycle.
- WRITE: write=1, addr=BASE_ADDR+4*idx, wdata=cfg_words_i[idx].
  - Completion with error=1: go to FAIL with ERR_BUS.
  - Otherwise, without verify: if idx==NUM_WORDS-1 go to DONE, else idx++ and stay in WRITE.
  - Otherwise, with verify: go to READ at the same idx.
- READ: write=0, same addr.
  - Completion with error=1: FAIL with ERR_BUS.
  - rdata != cfg_words_i[idx]: FAIL with ERR_MISMATCH.
  - Otherwise advance exactly as in WRITE.
- Timeout: a wait counter resets at the start of each beat and increments every cycle with valid=1 and ready=0. When it reaches TIMEOUT_CYCLES: FAIL with ERR_TIMEOUT and valid drops. No beat is ever abandoned for any other reason.
- DONE: done_o=1, busy_o=0, then return to IDLE. Status stays sticky until the next start.
- FAIL: err_o=1, err_idx_o=idx, busy_o=0, then return to IDLE. No further bus traffic.
- start_i while busy_o=1 is ignored.
- Throughput with ready tied to 1 and verify off: one word per cycle. First valid is at start+1; done_o rises at start+NUM_WORDS+1. With verify on: two cycles per word.
- Reset asserted mid-sequence: valid and all outputs clear asynchronously. There is no resume; a new start_i is required.
- idx is 8 bits and never wraps, because termination is compared against NUM_WORDS-1.

Optional Feature:
ACCT_LOADER_VERIFY_EN
- Defined: READ state and readback compare are built; ERR_MISMATCH is reachable. Locked registers that read as 0 will report a mismatch, which is intended.
- Undefined: WRITE-only sequence; READ logic and compare are not built.

Decomposition:
- Package acct_loader_pkg: state_e {IDLE, WRITE, READ, DONE, FAIL}; err_e {ERR_NONE, ERR_BUS, ERR_TIMEOUT, ERR_MISMATCH}; WSTRB_ALL constant.
- Sub-module acct_loader_timer: per-beat wait counter with clear/enable inputs and an expired output; counter width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
1. Reset, ready=1, error=0, verify off, NUM_WORDS=9, start at cycle 0 -> writes to 0x00..0x20 in cycles 1..9 with matching wdata, done_o=1 at cycle 10, err_o=0.
2. Slave holds ready=0 for 3 cycles on word 2 -> addr 0x08 and wdata stable and valid=1 for 4 cycles, no timeout, sequence completes.
3. error=1 on the write to word 4 -> err_o=1, err_code_o=ERR_BUS, err_idx_o=4, no valid afterwards, done_o=0.
4. ready stuck at 0, TIMEOUT_CYCLES=16 -> FAIL exactly 16 cycles after valid rises, err_code_o=ERR_TIMEOUT, err_idx_o=0.
5. Verify on, slave returns rdata=0 for words 6..8 (read-locked) -> ERR_MISMATCH, err_idx_o=6, words 0..6 were written.
6. rst_ni low during word 3, then start again -> valid clears immediately, busy_o=0; second run starts at 0x00 and completes normally.
